// File: rtl/regfile_pkg.sv
// Shared types and constants for the parametrised register file.
// Holds the init FSM encoding and the FP demo preload image.
package regfile_pkg;

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } state_e;

  localparam logic [31:0] FP_S0_INIT = 32'h41C1_0000;  // 24.125
  localparam logic [31:0] FP_S1_INIT = 32'h446C_B000;  // 946.75
  localparam int          S0_IDX     = 16;
  localparam int          S1_IDX     = 17;

endpackage

// File: rtl/regfile_init_seq.sv
// Post-reset initialisation sequencer: walks every register once, then holds RUN.
// One entry per cycle; init_done rises exactly DEPTH edges after reset release.
module regfile_init_seq
  import regfile_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int ADDR_W     = 5,
  parameter int PRELOAD_EN = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic              init_we,
  output logic [ADDR_W-1:0] init_addr,
  output logic [DATA_W-1:0] init_data,
  output logic              init_done
);

  localparam int DEPTH   = 2 ** ADDR_W;
  localparam bit PRELOAD = (PRELOAD_EN == 1) && (DEPTH > 17);

  state_e            r_state;
  state_e            w_state_nxt;
  logic [ADDR_W-1:0] r_idx;
  logic [ADDR_W-1:0] w_idx_nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= INIT;
      r_idx   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_idx   <= w_idx_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    init_we     = 1'b0;
    init_addr   = r_idx;
    init_data   = '0;
    init_done   = 1'b0;
    case (r_state)
      INIT: begin
        init_we = 1'b1;
        if (PRELOAD && (32'(r_idx) == S0_IDX)) init_data = DATA_W'(FP_S0_INIT);
        if (PRELOAD && (32'(r_idx) == S1_IDX)) init_data = DATA_W'(FP_S1_INIT);
        // Last index is all-ones, so the counter wraps back to 0 on exit.
        if (&r_idx) w_state_nxt = RUN;
        w_idx_nxt = r_idx + 1'b1;
      end
      RUN: begin
        init_done = 1'b1;
      end
      default: begin
        w_state_nxt = INIT;
      end
    endcase
  end

endmodule

// File: rtl/regfile_scoreboard.sv
// Multi-port register file with init sequencer, write-to-read bypass and busy scoreboard.
// Reads are combinational (zero latency); no backpressure, writes/issues ignored until init_done.
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int ADDR_W     = 5,
  parameter int NUM_RD     = 2,
  parameter int PRELOAD_EN = 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  output logic [NUM_RD-1:0]        rd_busy,
  input  logic                     wr_en,
  input  logic [ADDR_W-1:0]        wr_addr,
  input  logic [DATA_W-1:0]        wr_data,
  input  logic                     issue_en,
  input  logic [ADDR_W-1:0]        issue_addr,
  output logic                     init_done
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic              w_init_we;
  logic [ADDR_W-1:0] w_init_addr;
  logic [DATA_W-1:0] w_init_data;
  logic              w_init_done;

  regfile_init_seq #(
    .DATA_W    (DATA_W),
    .ADDR_W    (ADDR_W),
    .PRELOAD_EN(PRELOAD_EN)
  ) u_init_seq (
    .clk      (clk),
    .rst_n    (rst_n),
    .init_we  (w_init_we),
    .init_addr(w_init_addr),
    .init_data(w_init_data),
    .init_done(w_init_done)
  );

  assign init_done = w_init_done;

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [DEPTH-1:0]  r_busy;
  logic [DEPTH-1:0]  w_busy_nxt;
  logic              w_run_wr;
  logic              w_mem_we;
  logic [ADDR_W-1:0] w_mem_addr;
  logic [DATA_W-1:0] w_mem_data;

  assign w_run_wr   = w_init_done & wr_en & (wr_addr != '0);
  assign w_mem_we   = w_init_we | w_run_wr;
  assign w_mem_addr = w_init_we ? w_init_addr : wr_addr;
  assign w_mem_data = w_init_we ? w_init_data : wr_data;

  // Storage needs no reset: the init walk defines every entry before RUN.
  always_ff @(posedge clk) begin
    if (w_mem_we) r_mem[w_mem_addr] <= w_mem_data;
  end

  // A same-edge issue wins over a completing write to the same register.
  always_comb begin
    w_busy_nxt = r_busy;
    if (wr_en) w_busy_nxt[wr_addr] = 1'b0;
    if (issue_en && (issue_addr != '0)) w_busy_nxt[issue_addr] = 1'b1;
    w_busy_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_busy <= '0;
    end else if (w_init_done) begin
      r_busy <= w_busy_nxt;
    end
  end

  for (genvar g = 0; g < NUM_RD; g++) begin : g_rd
    logic [ADDR_W-1:0] w_ra;
    logic              w_hit;

    assign w_ra  = rd_addr[g*ADDR_W +: ADDR_W];
    assign w_hit = w_run_wr & (wr_addr == w_ra);

    assign rd_data[g*DATA_W +: DATA_W] = (!w_init_done || (w_ra == '0)) ? '0 :
                                         w_hit ? wr_data : r_mem[w_ra];
    assign rd_busy[g] = w_init_done & r_busy[w_ra] & ~w_hit;
  end

endmodule
